mac_neuron: RTL

Sequential fixed-point multiply-accumulate neuron that produces the masked pre-activation share consumed by the ReLU stage. It accepts one weight/activation term per valid cycle, accumulates K terms, then subtracts the garbler's mask r1 and emits x - r1. That value is the exact e_input format the ReLU stage expects. The block sits directly upstream of ReLU in the circuit_synthesis layer pipeline.

---
 rtl/mac_neuron_pkg.sv | 14 +
 rtl/mac_neuron_fxp_mul.sv | 19 +
 rtl/mac_neuron.sv | 85 ++++++++
 3 files changed

// File: rtl/mac_neuron_pkg.sv
// rtl/mac_neuron_pkg.sv - shared pipeline types and helpers for the neuron stages
package mac_neuron_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Counter width for K terms; a single-term neuron still needs one bit.
  function automatic int cnt_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/mac_neuron_fxp_mul.sv
// rtl/mac_neuron_fxp_mul.sv - signed fixed-point multiply, floor-rescaled and truncated to N bits
module fxp_mul #(
  parameter int N    = 8,
  parameter int FRAC = 4
) (
  input  logic [N-1:0] w_i,
  input  logic [N-1:0] a_i,
  output logic [N-1:0] p_o
);

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] scaled;

  // Arithmetic shift rounds toward -inf, which is the intended rescale.
  assign prod   = $signed(w_i) * $signed(a_i);
  assign scaled = prod >>> FRAC;
  assign p_o    = scaled[N-1:0];

endmodule

// File: rtl/mac_neuron.sv
// rtl/mac_neuron.sv - K-term MAC neuron emitting the masked pre-activation x - r1
module mac_neuron
  import mac_neuron_pkg::*;
#(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int FRAC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] g_input,
  input  logic [N-1:0]   e_input,
  input  logic           e_valid,
  output logic [N-1:0]   o,
  output logic           o_valid
);

  localparam int CNT_W = cnt_w(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     acc_d;
  logic [N-1:0]     o_q;
  logic             o_valid_q;
  logic [N-1:0]     w;
  logic [N-1:0]     r1;
  logic [N-1:0]     p;

  assign w  = g_input[2*N-1:N];
  assign r1 = g_input[N-1:0];

  fxp_mul #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mul (
    .w_i (w),
    .a_i (e_input),
    .p_o (p)
  );

  assign acc_d = acc_q + p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          o_valid_q <= 1'b0;
          if (e_valid) begin
            if (cnt_q == CNT_LAST) begin
              o_q       <= acc_d - r1;
              acc_q     <= '0;
              cnt_q     <= '0;
              o_valid_q <= 1'b1;
              state_q   <= ST_EMIT;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        // One-cycle bubble: any term offered here is dropped.
        ST_EMIT: begin
          o_valid_q <= 1'b0;
          state_q   <= ST_ACC;
        end
        default: begin
          o_valid_q <= 1'b0;
          state_q   <= ST_ACC;
        end
      endcase
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;

endmodule
